alu: RTL and testbench

//  32-bit integer ALU for the single-cycle MIPS datapath (EX stage).
//  - Combinational result ALUOut and next-flag word NFlag from x, y, ALUOp, shamt and the current Flag word.
//  - Registered copy NFlagQ of NFlag for the control/flag logic.
//  - The clock and reset only drive the NFlagQ register.

---
 rtl/alu_if.sv | 29 ++
 rtl/alu.sv | 67 ++++++
 tb/tb_alu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// alu_if: operand/result bundle for the EX-stage ALU.
//   x, y    operands A (rs) and B (rt / immediate)
//   ALUOp   operation select
//   shamt   shift amount; bit 5 set means the shift result is zero
//   Flag    current flag word
//   ALUOut  combinational result
//   NFlag   combinational next flag word
//   NFlagQ  NFlag registered on clk
// The master drives operands and reads results. The slave is the ALU.
interface alu_if;
   logic [31:0] x;
   logic [31:0] y;
   logic [2:0]  ALUOp;
   logic [5:0]  shamt;
   logic [31:0] Flag;
   logic [31:0] ALUOut;
   logic [31:0] NFlag;
   logic [31:0] NFlagQ;

   modport master (
      output x, y, ALUOp, shamt, Flag,
      input  ALUOut, NFlag, NFlagQ
   );

   modport slave (
      input  x, y, ALUOp, shamt, Flag,
      output ALUOut, NFlag, NFlagQ
   );
endinterface

// File: rtl/alu.sv
// alu: 32-bit integer ALU for the single-cycle MIPS datapath (EX stage).
//   clk  system clock. It only loads NFlagQ.
//   rst  asynchronous, active-high. It clears NFlagQ only.
//   bus  alu_if.slave. It carries the operands, ALUOut, NFlag and NFlagQ.
// ALUOut and NFlag are purely combinational. NFlagQ loads NFlag on every rising edge of clk.
// Flag bits 31:2 pass straight through to NFlag.
// Flag bits 1:0 are replaced by the zero flag and the overflow flag.
module alu (
   input  logic   clk,
   input  logic   rst,
   alu_if.slave   bus
);

   localparam logic [2:0] ALU_OP_ADD  = 3'b000;
   localparam logic [2:0] ALU_OP_SUB  = 3'b001;
   localparam logic [2:0] ALU_OP_AND  = 3'b010;
   localparam logic [2:0] ALU_OP_OR   = 3'b011;
   localparam logic [2:0] ALU_OP_LESS = 3'b100;
   localparam logic [2:0] ALU_OP_B    = 3'b101;
   localparam logic [2:0] ALU_OP_SLL  = 3'b110;
   localparam logic [2:0] ALU_OP_SRL  = 3'b111;

   logic [31:0] result;
   logic        ovf;
   logic [31:0] diff;
   logic        unused_flag_lsbs;

   // Flag[1:0] is always overwritten, so those input bits are never read.
   assign unused_flag_lsbs = ^bus.Flag[1:0];

   assign diff = bus.x - bus.y;

   always_comb begin
      result = 32'd0;
      ovf    = 1'b0;
      case (bus.ALUOp)
         ALU_OP_ADD: begin
            result = bus.x + bus.y;
            ovf    = (bus.x[31] == bus.y[31]) && (result[31] != bus.x[31]);
         end
         ALU_OP_SUB: begin
            result = diff;
            ovf    = (bus.x[31] != bus.y[31]) && (result[31] != bus.x[31]);
         end
         ALU_OP_AND:  result = bus.x & bus.y;
         ALU_OP_OR:   result = bus.x | bus.y;
         ALU_OP_LESS: result = {31'd0, ($signed(bus.x) < $signed(bus.y))};
         ALU_OP_B:    result = bus.y;
         // A shift amount of 32 or more clears the result.
         ALU_OP_SLL:  result = bus.shamt[5] ? 32'd0 : (bus.y << bus.shamt[4:0]);
         ALU_OP_SRL:  result = bus.shamt[5] ? 32'd0 : (bus.y >> bus.shamt[4:0]);
         default:     result = 32'd0;
      endcase
   end

   assign bus.ALUOut = result;
   assign bus.NFlag  = {bus.Flag[31:2], (result == 32'd0), ovf};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.NFlagQ <= 32'd0;
      end else begin
         bus.NFlagQ <= bus.NFlag;
      end
   end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

   typedef struct {
      logic [31:0] out;
      logic [31:0] nflag;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_if bus ();

   alu dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   // Reference model. It uses wide signed arithmetic, and the flag bits come from the
   // mathematical definitions.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [5:0] sh,
                                  input logic [31:0] flag, input string name);
      exp_t   e;
      longint sa, sb_v, wide;
      logic   ov;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      ov   = 1'b0;
      wide = 0;
      case (op)
         3'd0: begin wide = sa + sb_v; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
         3'd1: begin wide = sa - sb_v; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
         3'd2: wide = longint'(a & b);
         3'd3: wide = longint'(a | b);
         3'd4: wide = (sa < sb_v) ? 1 : 0;
         3'd5: wide = longint'(b);
         3'd6: wide = (sh >= 6'd32) ? 0 : longint'({32'd0, b} << sh);
         default: wide = (sh >= 6'd32) ? 0 : longint'(b >> sh);
      endcase
      e.out   = wide[31:0];
      e.nflag = {flag[31:2], (e.out == 32'd0), ov};
      e.name  = name;
      return e;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sh, input logic [31:0] flag);
      bus.ALUOp = op;
      bus.x     = a;
      bus.y     = b;
      bus.shamt = sh;
      bus.Flag  = flag;
   endtask

   task automatic push_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] sh, input logic [31:0] flag, input string name);
      @(negedge clk);
      drive(op, a, b, sh, flag);
      sb.push_back(model(op, a, b, sh, flag, name));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d expected=0 pending", sb.size());
         sb.delete();
      end
   endtask

   // The monitor checks the results one step after each rising edge. The inputs were
   // applied at the preceding falling edge, so ALUOut, NFlag and NFlagQ all refer to
   // the same vector.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.name, "_out"},   bus.ALUOut, e.out);
            check({e.name, "_nflag"}, bus.NFlag,  e.nflag);
            check({e.name, "_nflagq"}, bus.NFlagQ, e.nflag);
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [5:0]  sh;
      rst = 1'b1;
      drive(3'd0, 32'd0, 32'd0, 6'd0, 32'd0);
      #1;
      check("reset_nflagq", bus.NFlagQ, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      push_vec(3'd1, 32'd300, 32'd300, 6'd0, 32'd0, "sub_zero");
      push_vec(3'd0, 32'd100, 32'd200, 6'd0, 32'd0, "add");
      push_vec(3'd0, 32'h7fffffff, 32'd1, 6'd0, 32'd0, "add_ovf");
      push_vec(3'd1, 32'd100, 32'd200, 6'd0, 32'd0, "sub_neg");
      push_vec(3'd1, 32'h70000000, 32'h90000000, 6'd0, 32'd0, "sub_ovf");
      push_vec(3'd2, 32'd100, 32'd200, 6'd0, 32'd0, "and");
      push_vec(3'd3, 32'd100, 32'd200, 6'd0, 32'd0, "or");
      push_vec(3'd4, 32'd100, 32'd200, 6'd0, 32'd0, "less");
      push_vec(3'd5, 32'd100, 32'd200, 6'd0, 32'd0, "pass_b");
      push_vec(3'd4, 32'hffffffff, 32'd1, 6'd0, 32'd0, "less_signed");
      push_vec(3'd0, 32'h80000000, 32'h80000000, 6'd0, 32'hfffffffc, "add_ovf_zero");
      push_vec(3'd6, 32'd0, 32'h00000003, 6'd31, 32'd0, "sll_31");
      push_vec(3'd6, 32'd0, 32'hffffffff, 6'd32, 32'd0, "sll_big");
      push_vec(3'd7, 32'd0, 32'h80000000, 6'd31, 32'd0, "srl_31");
      push_vec(3'd7, 32'd0, 32'hffffffff, 6'd40, 32'd0, "srl_big");
      drain(10);

      // Assert rst between clock edges. NFlagQ must clear at once. The combinational
      // outputs must not change.
      @(negedge clk);
      drive(3'd0, 32'd100, 32'd200, 6'd0, 32'ha5a50000);
      @(posedge clk);
      #1;
      check("pre_rst_nflagq", bus.NFlagQ, 32'ha5a50000);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_nflagq", bus.NFlagQ, 32'd0);
      check("mid_rst_out",    bus.ALUOut, 32'd300);
      check("mid_rst_nflag",  bus.NFlag,  32'ha5a50000);
      @(posedge clk);
      #1;
      check("held_rst_nflagq", bus.NFlagQ, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push_vec(3'd0, 32'd100, 32'd200, 6'd0, 32'ha5a50000, "post_rst");

      for (int i = 0; i < 400; i++) begin
         a  = $urandom;
         op = 3'($urandom_range(0, 7));
         sh = 6'($urandom_range(0, 63));
         case ($urandom_range(0, 3))
            0: b = a;
            1: b = 32'($urandom_range(0, 15));
            2: b = {a[31], 31'($urandom)};
            default: b = $urandom;
         endcase
         push_vec(op, a, b, sh, $urandom, "rand");
      end
      drain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
